uart_tx_frame: RTL and testbench

Parametrised UART transmitter that integrates the bit timer, bit counter, shift register and control FSM into a single block, with configurable data width, stop-bit count, baud divider and runtime parity polarity. It sits between the processor's memory-mapped UART register and the `tx` pin. It replaces the push-button `tx_send` start with a valid/ready byte handshake and asserts a one-cycle completion pulse per frame.

---
 rtl/uart_tx_frame_if.sv | 12 +
 rtl/uart_tx_frame.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_frame.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// Byte handshake between the UART register block (master) and uart_tx_frame (slave).
interface uart_tx_frame_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              parity_odd;

  modport master (output tx_data, output tx_valid, output parity_odd, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input parity_odd, output tx_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: bit timer, bit counter, shift register and control FSM in one block.
// Define UART_TX_PARITY_EN to include the parity bit state; otherwise DATA goes straight to STOP.
module uart_tx_frame #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_frame_if.slave  bus,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done,
  output logic [2:0]      tx_state_out
);

  localparam int TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TMR_W-1:0]   r_timer;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0]  r_shift;
  logic               r_tx;
  logic               w_tx_nxt;
  logic               w_busy;
  logic               w_end_bit;
  logic               w_load;
  logic               w_shift;
  logic               w_cnt_inc;
  logic               w_cnt_clr;

`ifdef UART_TX_PARITY_EN
  logic               r_parity;
`else
  logic               w_unused_parity;
  assign w_unused_parity = bus.parity_odd;
`endif

  assign w_busy    = (r_state == START) || (r_state == DATA) ||
                     (r_state == PARITY) || (r_state == STOP);
  assign w_end_bit = w_busy && (r_timer == TMR_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.tx_valid) begin
          w_load      = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_end_bit) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_end_bit) begin
          w_shift = 1'b1;
          if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
            w_cnt_clr = 1'b1;
`ifdef UART_TX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_end_bit) w_state_nxt = STOP;
      end
`endif
      STOP: begin
        // The bit counter is reused to count stop-bit periods.
        if (w_end_bit) begin
          if (r_bit_cnt == CNT_W'(STOP_BITS - 1)) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_tx_nxt = 1'b1;
    case (r_state)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = r_shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_nxt = r_parity;
`endif
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (!w_busy || w_end_bit) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
    end else if (w_load || w_cnt_clr) begin
      r_bit_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
    end else if (w_load) begin
      r_shift <= bus.tx_data;
    end else if (w_shift) begin
      r_shift <= r_shift >> 1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_parity <= 1'b0;
    else if (w_load) r_parity <= (^bus.tx_data) ^ bus.parity_odd;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tx <= 1'b1;
    else     r_tx <= w_tx_nxt;
  end

  assign tx           = r_tx;
  assign bus.tx_ready = (r_state == IDLE);
  assign tx_busy      = w_busy;
  assign tx_done      = (r_state == DONE);
  assign tx_state_out = r_state;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: two instances (8N1-style and 7-bit/2-stop) at 4 clocks per bit.
module tb_uart_tx_frame;

  localparam int unsigned CPB = 4;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
  localparam logic [15:0] FR_A5 = 16'({1'b1, 1'b0, 8'hA5, 1'b0});
  localparam logic [15:0] FR_00 = 16'({1'b1, 1'b1, 8'h00, 1'b0});
  localparam logic [15:0] FR_FF = 16'({1'b1, 1'b0, 8'hFF, 1'b0});
  localparam logic [15:0] FR_12 = 16'({1'b1, 1'b0, 8'h12, 1'b0});
  localparam logic [15:0] FR_34 = 16'({1'b1, 1'b1, 8'h34, 1'b0});
  localparam logic [15:0] FR_55 = 16'({2'b11, 1'b0, 7'h55, 1'b0});
  localparam logic        SAW3_EXP = 1'b1;
`else
  localparam int unsigned NBITS = 10;
  localparam logic [15:0] FR_A5 = 16'({1'b1, 8'hA5, 1'b0});
  localparam logic [15:0] FR_00 = 16'({1'b1, 8'h00, 1'b0});
  localparam logic [15:0] FR_FF = 16'({1'b1, 8'hFF, 1'b0});
  localparam logic [15:0] FR_12 = 16'({1'b1, 8'h12, 1'b0});
  localparam logic [15:0] FR_34 = 16'({1'b1, 8'h34, 1'b0});
  localparam logic [15:0] FR_55 = 16'({2'b11, 7'h55, 1'b0});
  localparam logic        SAW3_EXP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;
  logic [2:0] st_a, st_b;

  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned cyc;
  int unsigned last_acc_a;
  int unsigned acc1;
  int unsigned done_cnt_a;
  int unsigned done_cnt_b;
  logic        saw3;

  uart_tx_frame_if #(.DATA_W(8)) ifa ();
  uart_tx_frame_if #(.DATA_W(7)) ifb ();

  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa),
    .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a), .tx_state_out(st_a)
  );

  uart_tx_frame #(.DATA_W(7), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb),
    .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b), .tx_state_out(st_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ifa.tx_valid && ifa.tx_ready) last_acc_a <= cyc;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (st_a == 3'd3 || st_b == 3'd3) saw3 <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic accept_a(input logic [7:0] d, input logic podd);
    int unsigned n = 0;
    @(negedge clk);
    while (!ifa.tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("a_ready_wait", 32'(ifa.tx_ready), 32'd1);
    ifa.tx_data    = d;
    ifa.parity_odd = podd;
    ifa.tx_valid   = 1'b1;
    @(posedge clk);
  endtask

  task automatic accept_b(input logic [6:0] d, input logic podd);
    int unsigned n = 0;
    @(negedge clk);
    while (!ifb.tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b_ready_wait", 32'(ifb.tx_ready), 32'd1);
    ifb.tx_data    = d;
    ifb.parity_odd = podd;
    ifb.tx_valid   = 1'b1;
    @(posedge clk);
  endtask

  // Called right after the acceptance edge; checks every line cycle of the frame plus DONE/IDLE.
  task automatic capture(input bit sel, input logic [15:0] fr, input bit keep_valid, input string tag);
    @(negedge clk);
    if (!keep_valid) begin
      if (sel) ifb.tx_valid = 1'b0;
      else     ifa.tx_valid = 1'b0;
    end
    check({tag, "_pre_tx"}, 32'(sel ? tx_b : tx_a), 32'd1);
    check({tag, "_start_state"}, 32'(sel ? st_b : st_a), 32'd1);
    check({tag, "_busy"}, 32'(sel ? busy_b : busy_a), 32'd1);
    check({tag, "_not_ready"}, 32'(sel ? ifb.tx_ready : ifa.tx_ready), 32'd0);
    for (int unsigned i = 0; i < NBITS * CPB; i++) begin
      @(negedge clk);
      check({tag, "_line"}, 32'(sel ? tx_b : tx_a), 32'(fr[i / CPB]));
    end
    check({tag, "_done"}, 32'(sel ? done_b : done_a), 32'd1);
    check({tag, "_done_state"}, 32'(sel ? st_b : st_a), 32'd5);
    @(negedge clk);
    check({tag, "_idle_tx"}, 32'(sel ? tx_b : tx_a), 32'd1);
    check({tag, "_done_off"}, 32'(sel ? done_b : done_a), 32'd0);
    check({tag, "_ready_back"}, 32'(sel ? ifb.tx_ready : ifa.tx_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; last_acc_a = 0; acc1 = 0;
    done_cnt_a = 0; done_cnt_b = 0; saw3 = 1'b0;
    rst = 1'b1;
    ifa.tx_data = '0; ifa.tx_valid = 1'b0; ifa.parity_odd = 1'b0;
    ifb.tx_data = '0; ifb.tx_valid = 1'b0; ifb.parity_odd = 1'b0;

    @(negedge clk);
    check("rst_tx_a", 32'(tx_a), 32'd1);
    check("rst_ready_a", 32'(ifa.tx_ready), 32'd1);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_state_a", 32'(st_a), 32'd0);
    check("rst_tx_b", 32'(tx_b), 32'd1);
    check("rst_state_b", 32'(st_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_tx_a", 32'(tx_a), 32'd1);
    check("idle_ready_a", 32'(ifa.tx_ready), 32'd1);

    accept_a(8'hA5, 1'b0);
    capture(1'b0, FR_A5, 1'b0, "a5_even");
    accept_a(8'h00, 1'b1);
    capture(1'b0, FR_00, 1'b0, "00_odd");
    accept_a(8'hFF, 1'b0);
    capture(1'b0, FR_FF, 1'b0, "ff_even");

    // Back-to-back with tx_valid held; tx_data is changed right after the first acceptance.
    accept_a(8'h12, 1'b0);
    #1;
    acc1 = last_acc_a;
    ifa.tx_data = 8'h34;
    capture(1'b0, FR_12, 1'b1, "b2b_12");
    capture(1'b0, FR_34, 1'b0, "b2b_34");
    check("b2b_spacing", last_acc_a - acc1, 32'(NBITS * CPB + 2));
    check("done_count_5", done_cnt_a, 32'd5);

    // Abort mid-frame during data bit 3 (a zero bit of 0xA5).
    accept_a(8'hA5, 1'b0);
    @(negedge clk);
    ifa.tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("abort_state", 32'(st_a), 32'd2);
    check("abort_pre_tx", 32'(tx_a), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("abort_tx_async", 32'(tx_a), 32'd1);
    check("abort_state_rst", 32'(st_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(ifa.tx_ready), 32'd1);
    check("abort_tx_idle", 32'(tx_a), 32'd1);
    check("abort_no_done", done_cnt_a, 32'd5);
    accept_a(8'hA5, 1'b0);
    capture(1'b0, FR_A5, 1'b0, "after_abort");

    accept_b(7'h55, 1'b0);
    capture(1'b1, FR_55, 1'b0, "b_55_2stop");

    check("done_count_a", done_cnt_a, 32'd6);
    check("done_count_b", done_cnt_b, 32'd1);
    check("state3_seen", 32'(saw3), 32'(SAW3_EXP));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
